// File: rtl/butterfly_pkg.sv
// Shared types for the ButterFly memory arbiter: FSM state encoding and the
// captured memory request register layout.
package butterfly_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/butterfly_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first.
// Define BUTTERFLY_ARB_STARVE_GUARD_EN to bound how long fetch can be starved.
module butterfly_mem_arbiter
  import butterfly_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_valid_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_wstrb_i,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  arb_state_e state_q, state_d;
  mem_req_t   req_q, req_d;
  logic       mem_valid_q, mem_valid_d;
  logic       guard_trip;

`ifdef BUTTERFLY_ARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] SAT   = '1;

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  assign guard_trip = (starve_q == LIMIT) && if_valid_i;

  // Counts data grants that overtook a waiting fetch; saturates instead of wrapping.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ARB_IDLE) begin
      if (d_valid_i && !guard_trip) begin
        if (!if_valid_i)          starve_d = '0;
        else if (starve_q != SAT) starve_d = starve_q + 1'b1;
      end else if (if_valid_i) begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign guard_trip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mem_valid_d = mem_valid_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_valid_i && !guard_trip) begin
          req_d       = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, wstrb: d_wstrb_i};
          mem_valid_d = 1'b1;
          state_d     = ARB_BUSY_D;
        end else if (if_valid_i) begin
          req_d       = '{we: 1'b0, addr: if_addr_i, wdata: 32'h0, wstrb: 4'h0};
          mem_valid_d = 1'b1;
          state_d     = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // Request fields stay frozen until completion; the requester's valid is not re-sampled.
        if (mem_ready_i) begin
          mem_valid_d = 1'b0;
          state_d     = ARB_IDLE;
        end
      end
      default: begin
        mem_valid_d = 1'b0;
        state_d     = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB_IDLE;
      req_q       <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign mem_wstrb_o = req_q.wstrb;

  assign if_ready_o  = (state_q == ARB_BUSY_I) && mem_ready_i;
  assign d_ready_o   = (state_q == ARB_BUSY_D) && mem_ready_i;
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_butterfly_mem_arbiter.sv
// Directed self-checking bench for butterfly_mem_arbiter; expectations follow
// the guard build selected by BUTTERFLY_ARB_STARVE_GUARD_EN.
module tb_butterfly_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_valid_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_rdata_o;
  logic        d_valid_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_wstrb_i;
  logic        d_ready_o;
  logic [31:0] d_rdata_o;
  logic        mem_valid_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;

  int num_checks = 0;
  int num_fails  = 0;

  butterfly_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_valid_i(if_valid_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
    .d_valid_i(d_valid_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i),
    .d_ready_o(d_ready_o), .d_rdata_o(d_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ifv, input logic [31:0] ifa,
                               input logic dv, input logic we, input logic [31:0] da,
                               input logic [31:0] dw, input logic [3:0] ds);
    if_valid_i = ifv; if_addr_i = ifa;
    d_valid_i  = dv;  d_we_i = we; d_addr_i = da; d_wdata_i = dw; d_wstrb_i = ds;
  endtask

  task automatic checkMem(input string tag, input logic v, input logic we,
                          input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    checkOutput({tag, "_valid"}, {31'h0, mem_valid_o}, {31'h0, v});
    checkOutput({tag, "_we"},    {31'h0, mem_we_o},    {31'h0, we});
    checkOutput({tag, "_addr"},  mem_addr_o,  a);
    checkOutput({tag, "_wdata"}, mem_wdata_o, w);
    checkOutput({tag, "_wstrb"}, {28'h0, mem_wstrb_o}, {28'h0, s});
  endtask

  task automatic checkReady(input string tag, input logic ir, input logic dr);
    checkOutput({tag, "_if_ready"}, {31'h0, if_ready_o}, {31'h0, ir});
    checkOutput({tag, "_d_ready"},  {31'h0, d_ready_o},  {31'h0, dr});
  endtask

  logic exp_seq [10];
  int   grants;

  initial begin
    rst_n_i = 1'b0; mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkMem("reset", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkReady("reset", 1'b0, 1'b0);
    @(negedge clk_i); @(negedge clk_i);
    rst_n_i = 1'b1;

    // Fetch only
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk_i);
    checkMem("fetch", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    checkReady("fetch_wait", 1'b0, 1'b0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
    checkReady("fetch_done", 1'b1, 1'b0);
    checkOutput("fetch_rdata", if_rdata_o, 32'h1234_5678);
    @(negedge clk_i);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready_i = 1'b0;
    checkOutput("fetch_after_valid", {31'h0, mem_valid_o}, 32'h0);

    // Simultaneous: store beats fetch, idle cycle, then fetch
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'h8000, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk_i);
    checkMem("simul_store", 1'b1, 1'b1, 32'h8000, 32'hDEAD_BEEF, 4'hF);
    mem_ready_i = 1'b1; #1;
    checkReady("simul_store_done", 1'b0, 1'b1);
    @(negedge clk_i);
    d_valid_i = 1'b0; mem_ready_i = 1'b0;
    checkOutput("simul_idle_valid", {31'h0, mem_valid_o}, 32'h0);
    @(negedge clk_i);
    checkMem("simul_fetch", 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE_0001; #1;
    checkReady("simul_fetch_done", 1'b1, 1'b0);
    @(negedge clk_i);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready_i = 1'b0;

    // Wait states: a load held by five cycles of mem_ready_i low
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      checkMem($sformatf("wait%0d", i), 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
      checkReady($sformatf("wait%0d", i), 1'b0, 1'b0);
      @(negedge clk_i);
    end
    mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D; #1;
    checkReady("wait_done", 1'b0, 1'b1);
    checkOutput("wait_rdata", d_rdata_o, 32'h0BAD_F00D);
    @(negedge clk_i);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready_i = 1'b0;

    // Starvation: continuous stores plus fetch, memory always ready
`ifdef BUTTERFLY_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 10; i++) exp_seq[i] = (i % 5 != 4);
`else
    for (int i = 0; i < 10; i++) exp_seq[i] = 1'b1;
`endif
    grants = 0;
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1, 32'h9000, 32'h1, 4'h1);
    mem_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_valid_o && grants < 10) begin
        checkOutput($sformatf("starve_grant%0d_we", grants), {31'h0, mem_we_o}, {31'h0, exp_seq[grants]});
        grants++;
      end
    end
    checkOutput("starve_grant_count", grants, 10);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk_i); @(negedge clk_i);
    mem_ready_i = 1'b0;

    // Reset while busy with a store and mem_ready_i pending
    applyStimulus(1'b1, 32'h400, 1'b1, 1'b1, 32'h300, 32'h55, 4'h3);
    @(negedge clk_i);
    checkMem("rst_busy", 1'b1, 1'b1, 32'h300, 32'h55, 4'h3);
    mem_ready_i = 1'b1; rst_n_i = 1'b0; #1;
    checkMem("rst_mid", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checkReady("rst_mid", 1'b0, 1'b0);
    @(negedge clk_i);
    mem_ready_i = 1'b0; rst_n_i = 1'b1;
    @(negedge clk_i);
    checkMem("rst_regrant", 1'b1, 1'b1, 32'h300, 32'h55, 4'h3);
    mem_ready_i = 1'b1; #1;
    checkReady("rst_regrant_done", 1'b0, 1'b1);
    @(negedge clk_i);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready_i = 1'b0;
    @(negedge clk_i);

    // mem_ready_i pulsed while idle
    mem_ready_i = 1'b1; #1;
    checkReady("idle_pulse", 1'b0, 1'b0);
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    checkOutput("idle_pulse_valid", {31'h0, mem_valid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

endmodule
